// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared FSM states, sizes and round-robin search for mux8_rr_arbiter
package mux_arb_pkg;

    typedef enum logic {IDLE, GRANT} state_t;

    localparam int NREQ  = 8;
    localparam int SEL_W = 3;

    // Returns {found, index}: first set bit of req scanning from last+1 upward, wrapping mod 8
    function automatic logic [SEL_W:0] rr_pick(input logic [NREQ-1:0] req, input logic [SEL_W-1:0] last);
        logic [SEL_W:0] r;
        logic [SEL_W-1:0] idx;
        r = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = last + SEL_W'(k);
            if (req[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

endpackage

// File: rtl/Mux8to1Nw.sv
// Mux8to1Nw: 8-to-1 multiplexer of n-bit words
module Mux8to1Nw #(
    parameter int n = 8
) (
    input  logic [n-1:0] d0,
    input  logic [n-1:0] d1,
    input  logic [n-1:0] d2,
    input  logic [n-1:0] d3,
    input  logic [n-1:0] d4,
    input  logic [n-1:0] d5,
    input  logic [n-1:0] d6,
    input  logic [n-1:0] d7,
    input  logic [2:0]   s,
    output logic [n-1:0] y
);

    logic [n-1:0] lo, hi;

    always_comb begin
        lo = s[1] ? (s[0] ? d3 : d2) : (s[0] ? d1 : d0);
        hi = s[1] ? (s[0] ? d7 : d6) : (s[0] ? d5 : d4);
        y  = s[2] ? hi : lo;
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: 8-way round-robin arbiter with bounded hold, steering the winner's data word to M
module mux8_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N        = 16,
    parameter int MAX_HOLD = 4
) (
    input  logic                 Clk,
    input  logic                 ResetN,
    input  logic [NREQ-1:0]      Req,
    input  logic [N-1:0]         DIn0,
    input  logic [N-1:0]         DIn1,
    input  logic [N-1:0]         DIn2,
    input  logic [N-1:0]         DIn3,
    input  logic [N-1:0]         DIn4,
    input  logic [N-1:0]         DIn5,
    input  logic [N-1:0]         DIn6,
    input  logic [N-1:0]         DIn7,
    output logic [NREQ-1:0]      Gnt,
    output logic [SEL_W-1:0]     Sel,
    output logic                 Valid,
    output logic [N-1:0]         M
);

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d, last_q, last_d, nxt;
    logic             valid_q, valid_d, take;
    logic [7:0]       hold_q, hold_d;
    logic [SEL_W:0]   pick_all, pick_oth;

    assign pick_all = rr_pick(Req, last_q);
    // Masking the current owner makes the search pick only among the other requesters
    assign pick_oth = rr_pick(Req & ~gnt_q, last_q);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        hold_d  = hold_q;
        last_d  = last_q;
        take    = 1'b0;
        nxt     = pick_oth[SEL_W-1:0];
        if (state_q == IDLE) begin
            take = pick_all[SEL_W];
            nxt  = pick_all[SEL_W-1:0];
        end else if (!Req[sel_q]) begin
            take = pick_oth[SEL_W];
            if (!pick_oth[SEL_W]) begin
                state_d = IDLE;
                gnt_d   = '0;
                valid_d = 1'b0;
                hold_d  = '0;
            end
        end else if (hold_q < HOLD_MAX) begin
            hold_d = hold_q + 8'd1;
        end else begin
            take   = pick_oth[SEL_W];
            hold_d = '0;
        end
        if (take) begin
            state_d = GRANT;
            gnt_d   = NREQ'(1) << nxt;
            sel_d   = nxt;
            last_d  = nxt;
            valid_d = 1'b1;
            hold_d  = '0;
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            hold_q  <= '0;
            last_q  <= 3'd7;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
        end
    end

    assign Gnt   = gnt_q;
    assign Sel   = sel_q;
    assign Valid = valid_q;

    Mux8to1Nw #(.n(N)) u_mux (
        .d0(DIn0), .d1(DIn1), .d2(DIn2), .d3(DIn3),
        .d4(DIn4), .d5(DIn5), .d6(DIn6), .d7(DIn7),
        .s (sel_q),
        .y (M)
    );

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb_mux8_rr_arbiter: scoreboard bench for mux8_rr_arbiter against a cycle-level reference model
module tb_mux8_rr_arbiter;

    localparam int N  = 16;
    localparam int MH = 4;

    typedef struct {
        logic       v;
        logic [2:0] s;
        logic [7:0] g;
    } exp_t;

    logic          Clk = 1'b0;
    logic          ResetN = 1'b0;
    logic [7:0]    Req = '0;
    logic [N-1:0]  din [8];
    logic [7:0]    Gnt;
    logic [2:0]    Sel;
    logic          Valid;
    logic [N-1:0]  M;

    int errors = 0;
    int checks = 0;

    exp_t q[$];
    exp_t e;

    logic       m_valid;
    logic [2:0] m_sel, m_last;
    int         m_hold;

    always #5 Clk = ~Clk;

    mux8_rr_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
        .Clk(Clk), .ResetN(ResetN), .Req(Req),
        .DIn0(din[0]), .DIn1(din[1]), .DIn2(din[2]), .DIn3(din[3]),
        .DIn4(din[4]), .DIn5(din[5]), .DIn6(din[6]), .DIn7(din[7]),
        .Gnt(Gnt), .Sel(Sel), .Valid(Valid), .M(M)
    );

    function automatic int search(input logic [7:0] r, input logic [2:0] last);
        for (int i = 1; i <= 8; i++)
            if (r[(int'(last) + i) % 8]) return (int'(last) + i) % 8;
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_sel   = 3'd0;
        m_last  = 3'd7;
        m_hold  = 0;
    endtask

    // Advance the model by one edge under request vector r and queue the expected outputs
    task automatic drive(input logic [7:0] r);
        int w;
        logic [7:0] oth;
        exp_t x;
        Req = r;
        oth = r;
        oth[m_sel] = 1'b0;
        w = -2;
        if (!m_valid) w = search(r, m_last);
        else if (!r[m_sel]) w = search(oth, m_last);
        else if (m_hold < MH - 1) m_hold++;
        else if (oth != 0) w = search(oth, m_last);
        else m_hold = 0;
        if (w >= 0) begin
            m_valid = 1'b1;
            m_sel   = 3'(w);
            m_last  = 3'(w);
            m_hold  = 0;
        end else if (w == -1) begin
            m_valid = 1'b0;
            m_hold  = 0;
        end
        x.v = m_valid;
        x.s = m_sel;
        x.g = m_valid ? (8'd1 << m_sel) : 8'd0;
        q.push_back(x);
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        ResetN = 1'b0;
        model_reset();
        q.delete();
        Req = '0;
        @(negedge Clk);
        ResetN = 1'b1;
    endtask

    task automatic test_reset();
        ResetN = 1'b0;
        model_reset();
        repeat (2) @(negedge Clk);
        checks++;
        if (Gnt !== 8'h00 || Sel !== 3'd0 || Valid !== 1'b0) begin
            errors++;
            $display("FAIL reset: Gnt=%h Sel=%0d Valid=%b, want 00 0 0", Gnt, Sel, Valid);
        end
        ResetN = 1'b1;
    endtask

    task automatic test_first_grant();
        do_reset();
        drive(8'h01);
        e = q.pop_front();
        checks++;
        if (Gnt !== 8'h01 || Sel !== 3'd0 || Valid !== 1'b1 || M !== din[0] || Gnt !== e.g) begin
            errors++;
            $display("FAIL first_grant: Gnt=%h Sel=%0d Valid=%b M=%h, want 01 0 1 %h", Gnt, Sel, Valid, M, din[0]);
        end
    endtask

    task automatic test_all_req();
        do_reset();
        for (int i = 0; i < 36; i++) begin
            drive(8'hFF);
            e = q.pop_front();
            checks++;
            if (Sel !== 3'((i / MH) % 8) || Sel !== e.s || Gnt !== e.g || Valid !== 1'b1 || M !== din[(i / MH) % 8]) begin
                errors++;
                $display("FAIL all_req[%0d]: Sel=%0d Gnt=%h Valid=%b, want Sel=%0d Gnt=%h", i, Sel, Gnt, Valid, (i / MH) % 8, e.g);
            end
        end
    endtask

    task automatic test_single_hold();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(8'h10);
            e = q.pop_front();
            checks++;
            if (Sel !== 3'd4 || Valid !== 1'b1 || Gnt !== 8'h10 || Gnt !== e.g) begin
                errors++;
                $display("FAIL single_hold[%0d]: Sel=%0d Valid=%b Gnt=%h, want 4 1 10", i, Sel, Valid, Gnt);
            end
        end
    endtask

    task automatic test_drop();
        logic [7:0] seq [4];
        logic [7:0] gexp [4];
        seq  = '{8'h04, 8'h84, 8'h80, 8'h00};
        gexp = '{8'h04, 8'h04, 8'h80, 8'h00};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(seq[i]);
            e = q.pop_front();
            checks++;
            if (Gnt !== gexp[i] || Gnt !== e.g || Valid !== e.v || (e.v && Sel !== e.s)) begin
                errors++;
                $display("FAIL drop[%0d]: Gnt=%h Sel=%0d Valid=%b, want Gnt=%h Sel=%0d Valid=%b", i, Gnt, Sel, Valid, gexp[i], e.s, e.v);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(8'h08);
        drive(8'h08);
        e = q.pop_front();
        e = q.pop_front();
        checks++;
        if (Sel !== 3'd3 || Valid !== 1'b1) begin
            errors++;
            $display("FAIL async_pre: Sel=%0d Valid=%b, want 3 1", Sel, Valid);
        end
        #2;
        ResetN = 1'b0;
        model_reset();
        #1;
        checks++;
        if (Gnt !== 8'h00 || Valid !== 1'b0 || Sel !== 3'd0) begin
            errors++;
            $display("FAIL async_reset: Gnt=%h Valid=%b Sel=%0d, want 00 0 0", Gnt, Valid, Sel);
        end
        @(negedge Clk);
        ResetN = 1'b1;
        drive(8'h24);
        e = q.pop_front();
        checks++;
        if (Sel !== 3'd2 || Gnt !== 8'h04 || Valid !== 1'b1 || Gnt !== e.g) begin
            errors++;
            $display("FAIL async_release: Sel=%0d Gnt=%h Valid=%b, want 2 04 1", Sel, Gnt, Valid);
        end
    endtask

    task automatic test_random();
        int wait_cnt [8];
        logic [7:0] r;
        logic [7:0] chk_f;
        do_reset();
        for (int k = 0; k < 8; k++) wait_cnt[k] = 0;
        for (int i = 0; i < 500; i++) begin
            for (int k = 0; k < 8; k++) din[k] = N'($urandom);
            r = 8'($urandom) & 8'($urandom);
            drive(r);
            e = q.pop_front();
            chk_f = Gnt & (Gnt - 8'd1);
            checks++;
            if (Gnt !== e.g || Valid !== e.v || (e.v && (Sel !== e.s || M !== din[e.s])) || chk_f !== 8'h00) begin
                errors++;
                $display("FAIL random[%0d]: Gnt=%h Sel=%0d Valid=%b M=%h, want Gnt=%h Sel=%0d Valid=%b M=%h", i, Gnt, Sel, Valid, M, e.g, e.s, e.v, din[e.s]);
            end
            for (int k = 0; k < 8; k++) begin
                wait_cnt[k] = (r[k] && !Gnt[k]) ? wait_cnt[k] + 1 : 0;
                if (wait_cnt[k] > 7 * MH + 1) begin
                    errors++;
                    $display("FAIL starvation: requester %0d waited %0d cycles, limit %0d", k, wait_cnt[k], 7 * MH + 1);
                    wait_cnt[k] = 0;
                end
            end
        end
        checks++;
    endtask

    initial begin
        for (int k = 0; k < 8; k++) din[k] = N'(16'h1111 * (k + 1));
        test_reset();
        test_first_grant();
        test_all_req();
        test_single_hold();
        test_drop();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux8_rr_arbiter.md
MUX8_RR_ARBITER -- requirements
Module: mux8_rr_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 16, meaning data width of each requester input and of the output.
REQ-002 The block SHALL have parameter MAX_HOLD, default 4, meaning the maximum consecutive grant cycles while other requesters wait (legal range 1..255).
REQ-003 Clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 ResetN  input  1  reset, asynchronous and active-low.
REQ-005 Req  input  8  per-requester request, bit i belongs to requester i.
REQ-006 DIn0..DIn7  input  N each  requester data words.
REQ-007 Gnt  output  8  one-hot grant, registered.
REQ-008 Sel  output  3  encoded index of the granted requester, registered.
REQ-009 Valid  output  1  high when a grant is active.
REQ-010 M  output  N  data of the granted requester (combinational from Sel); value when Valid=0 is DIn selected by Sel, don't-care to consumers.

Function
REQ-011 The FSM SHALL have two states: IDLE (no grant) and GRANT (one requester owns the mux).
REQ-012 IDLE -> GRANT on the first edge where Req != 0; Gnt, Sel and Valid SHALL update on that edge (1-cycle request-to-grant latency).
REQ-013 Winner selection SHALL be round-robin: search starts at index (Last+1) mod 8 and takes the first set Req bit, where Last is the most recently granted index.
REQ-014 Gnt SHALL always be one-hot in GRANT and all-zero in IDLE; Gnt[Sel] = 1 whenever Valid = 1.
REQ-015 In GRANT, while Req[Sel] stays high and HoldCnt < MAX_HOLD-1, the grant SHALL be held and HoldCnt SHALL increment.
REQ-016 When Req[Sel] is low at an edge, the grant SHALL move on that same edge to the next round-robin winner among the other requesters, or to IDLE if none request.
REQ-017 When HoldCnt reaches MAX_HOLD-1 with Req[Sel] high: if any other Req bit is set, the grant SHALL move to the next round-robin winner; otherwise the grant SHALL stay with Sel and HoldCnt SHALL reset to 0.
REQ-018 Every grant change (including IDLE -> GRANT) SHALL reset HoldCnt to 0 and set Last to the new Sel.
REQ-019 Req bits of non-granted requesters rising or falling mid-grant SHALL NOT change the current grant before REQ-016/REQ-017 conditions occur.
REQ-020 Index wrap-around SHALL be modulo 8 (after 7 comes 0).
REQ-021 HoldCnt SHALL be 8 bits wide and never exceed MAX_HOLD-1.

Reset
REQ-022 While ResetN = 0: state = IDLE, Gnt = 8'h00, Sel = 3'd0, Valid = 0, HoldCnt = 0, Last = 3'd7 (so requester 0 wins first).
REQ-023 Reset asserted mid-grant SHALL clear all outputs immediately, without waiting for Clk.
REQ-024 After ResetN rises, the first grant SHALL follow REQ-012/REQ-013 with Last = 7.

Structure
REQ-025 A shared package mux_arb_pkg SHALL hold the state enum (IDLE, GRANT), NREQ = 8 and SEL_W = 3.
REQ-026 The data path SHALL be one instance of the team's existing Mux8to1Nw (n = N), driven by Sel; the arbiter SHALL contain no other sub-module.
REQ-027 The round-robin search SHALL be a combinational function of Req and Last; all outputs except M SHALL be flops.

Verification
REQ-028 Reset, then Req = 8'h01 -> one edge later Gnt = 8'h01, Sel = 0, Valid = 1, M = DIn0.
REQ-029 Req = 8'hFF held constant, MAX_HOLD = 4 -> Sel sequence 0,0,0,0,1,1,1,1,2,... with wrap 7 -> 0.
REQ-030 Req = 8'h10 only, held 10 cycles -> Sel stays 4 throughout, Valid stays 1, HoldCnt wraps 0..3.
REQ-031 Grant on 2, Req = 8'h84, requester 2 drops -> next edge Sel = 7; requester 7 drops with Req = 0 -> IDLE, Gnt = 0.
REQ-032 ResetN pulled low mid-grant between edges -> Gnt = 0 and Valid = 0 immediately; after release with Req = 8'h24 -> Sel = 2 first.
REQ-033 Random Req for 500 cycles -> Gnt one-hot or zero every cycle, M = DIn[Sel], and no waiting requester waits more than 7*MAX_HOLD+1 cycles.
